// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: lamp codes, monitor state, phase encoding and successor helper for traffic_light_monitor.
package traffic_light_pkg;
  localparam logic [2:0] S0 = 3'b001;
  localparam logic [2:0] S1 = 3'b010;
  localparam logic [2:0] S2 = 3'b100;
  typedef enum logic [1:0] {UNLOCKED, TRACK, FAULT} mon_state_e;
  typedef enum logic [1:0] {PH_NONE, PH_S0, PH_S1, PH_S2} phase_e;
  function automatic logic [2:0] succ(input logic [2:0] cur);
    return {cur[0], cur[2:1]};
  endfunction
  function automatic phase_e to_phase(input logic [2:0] code);
    return code == S0 ? PH_S0 : code == S1 ? PH_S1 : code == S2 ? PH_S2 : PH_NONE;
  endfunction
endpackage

// File: rtl/traffic_light_dwell_counter.sv
// traffic_light_dwell_counter: saturating per-phase sample counter with MIN/MAX dwell compares.
module traffic_light_dwell_counter #(
  parameter int MIN_DWELL = 4,
  parameter int MAX_DWELL = 64,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load1,
  input  logic             inc,
  input  logic             zero,
  output logic [CNT_W-1:0] cnt,
  output logic             dwell_short,
  output logic             dwell_long
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb cnt_d = zero ? '0 : load1 ? CNT_W'(1) : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
  assign dwell_short = cnt_q < CNT_W'(MIN_DWELL);
  // an increment from MAX_DWELL lands on MAX_DWELL+1
  assign dwell_long = cnt_q == CNT_W'(MAX_DWELL);
endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of the one-hot lamp bus (order, codes, dwell, cycle count).
// Define TLM_DWELL_CHECK_EN to enable err_short/err_long; otherwise they are tied to 0.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int MIN_DWELL = 4,
  parameter int MAX_DWELL = 64,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       lamp,
  input  logic             clr,
  output logic [1:0]       phase,
  output logic             locked,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             err_code,
  output logic             err_seq,
  output logic             err_short,
  output logic             err_long
);
  mon_state_e state_d, state_q;
  phase_e phase_d, phase_q;
  logic [2:0] cur_d, cur_q;
  logic [CNT_W-1:0] cyc_d, cyc_q;
  logic locked_d, locked_q, err_code_d, err_code_q, err_seq_d, err_seq_q;
  logic load1, inc, zero, set_code, set_seq, set_short, set_long, dwell_short, dwell_long, legal;
  assign legal = lamp == S0 || lamp == S1 || lamp == S2;
  traffic_light_dwell_counter #(.MIN_DWELL(MIN_DWELL), .MAX_DWELL(MAX_DWELL), .CNT_W(CNT_W)) u_dwell (
    .clk(clk), .rst(rst), .load1(load1), .inc(inc), .zero(zero),
    .cnt(dwell), .dwell_short(dwell_short), .dwell_long(dwell_long)
  );
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cur_d = cur_q;
    cyc_d = cyc_q;
    {load1, inc, zero, set_code, set_seq, set_short, set_long} = '0;
    if (en) begin
      unique case (state_q)
        UNLOCKED:
          if (legal) begin
            state_d = TRACK;
            cur_d = lamp;
            phase_d = to_phase(lamp);
            load1 = 1'b1;
          end else set_code = 1'b1;
        TRACK:
          if (lamp == cur_q) begin
            inc = 1'b1;
            set_long = dwell_long;
          end else if (lamp == succ(cur_q)) begin
            set_short = dwell_short;
            cur_d = lamp;
            phase_d = to_phase(lamp);
            load1 = 1'b1;
            cyc_d = lamp == S0 ? cyc_q + 1'b1 : cyc_q;
          end else begin
            state_d = FAULT;
            phase_d = PH_NONE;
            zero = 1'b1;
            set_seq = legal;
            set_code = !legal;
          end
        FAULT:
          if (lamp == S0) begin
            state_d = TRACK;
            cur_d = S0;
            phase_d = PH_S0;
            load1 = 1'b1;
          end else set_code = !legal;
        default: state_d = UNLOCKED;
      endcase
    end
    locked_d = state_d == TRACK;
    // a new error in the same cycle as clr takes priority
    err_code_d = (err_code_q & ~clr) | set_code;
    err_seq_d = (err_seq_q & ~clr) | set_seq;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= UNLOCKED;
      phase_q <= PH_NONE;
      cur_q <= '0;
      cyc_q <= '0;
      locked_q <= 1'b0;
      err_code_q <= 1'b0;
      err_seq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cur_q <= cur_d;
      cyc_q <= cyc_d;
      locked_q <= locked_d;
      err_code_q <= err_code_d;
      err_seq_q <= err_seq_d;
    end
`ifdef TLM_DWELL_CHECK_EN
  logic err_short_q, err_long_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      err_short_q <= 1'b0;
      err_long_q <= 1'b0;
    end else begin
      err_short_q <= (err_short_q & ~clr) | set_short;
      err_long_q <= (err_long_q & ~clr) | set_long;
    end
  assign err_short = err_short_q;
  assign err_long = err_long_q;
`else
  logic unused_cmp;
  assign unused_cmp = set_short | set_long;
  assign err_short = 1'b0;
  assign err_long = 1'b0;
`endif
  assign phase = phase_q;
  assign locked = locked_q;
  assign cycle_cnt = cyc_q;
  assign err_code = err_code_q;
  assign err_seq = err_seq_q;
endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: vector table plus hand sequences, checked through an expected-value queue.
module tb_traffic_light_monitor;
  typedef struct packed {
    logic [1:0] phase;
    logic       locked;
    logic [7:0] dwell;
    logic [7:0] cyc;
    logic [3:0] err;
  } obs_t;
  typedef struct {
    logic       en;
    logic [2:0] lamp;
    logic       clr;
    obs_t       exp;
  } vec_t;
`ifdef TLM_DWELL_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, clr = 1'b0;
  logic [2:0] lamp = 3'b000;
  logic [1:0] phase;
  logic [7:0] dwell, cycle_cnt;
  logic locked, err_code, err_seq, err_short, err_long;
  obs_t act, sb[$];
  vec_t tbl[$];
  int ncmp = 0, nbad = 0;
  traffic_light_monitor dut (
    .clk(clk), .rst(rst), .en(en), .lamp(lamp), .clr(clr),
    .phase(phase), .locked(locked), .dwell(dwell), .cycle_cnt(cycle_cnt),
    .err_code(err_code), .err_seq(err_seq), .err_short(err_short), .err_long(err_long)
  );
  always #5 clk = ~clk;
  assign act = {phase, locked, dwell, cycle_cnt, err_code, err_seq, err_short, err_long};
  function automatic obs_t ob(input int ph, input int lk, input int dw, input int cy, input logic [3:0] e);
    obs_t o;
    o.phase = ph[1:0];
    o.locked = lk[0];
    o.dwell = dw[7:0];
    o.cyc = cy[7:0];
    o.err = e;
    return o;
  endfunction
  function automatic vec_t mk(input logic e, input logic [2:0] l, input logic c, input obs_t x);
    vec_t v;
    v.en = e;
    v.lamp = l;
    v.clr = c;
    v.exp = x;
    return v;
  endfunction
  task automatic check(input string nm);
    obs_t want;
    ncmp++;
    if (sb.size() == 0) begin
      nbad++;
      $display("FAIL %s: no expected entry queued", nm);
    end else begin
      want = sb.pop_front();
      if (act !== want) begin
        nbad++;
        $display("FAIL %s: got ph=%0d lk=%0d dw=%0d cy=%0d err(code,seq,short,long)=%b, want ph=%0d lk=%0d dw=%0d cy=%0d err=%b",
                 nm, act.phase, act.locked, act.dwell, act.cyc, act.err,
                 want.phase, want.locked, want.dwell, want.cyc, want.err);
      end
    end
  endtask
  task automatic apply(input vec_t v, input string nm);
    en = v.en;
    lamp = v.lamp;
    clr = v.clr;
    sb.push_back(v.exp);
    @(posedge clk);
    #1;
    check(nm);
  endtask
  initial begin
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(1, 3'b001, 0, ob(1, 1, i, 0, 4'b0000)));
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(1, 3'b100, 0, ob(3, 1, i, 0, 4'b0000)));
    for (int i = 1; i <= 4; i++) tbl.push_back(mk(1, 3'b010, 0, ob(2, 1, i, 0, 4'b0000)));
    tbl.push_back(mk(1, 3'b001, 0, ob(1, 1, 1, 1, 4'b0000)));
    for (int i = 2; i <= 4; i++) tbl.push_back(mk(1, 3'b001, 0, ob(1, 1, i, 1, 4'b0000)));
    for (int i = 1; i <= 2; i++) tbl.push_back(mk(1, 3'b100, 0, ob(3, 1, i, 1, 4'b0000)));
    tbl.push_back(mk(1, 3'b010, 0, ob(2, 1, 1, 1, {2'b00, CHK, 1'b0})));
    tbl.push_back(mk(1, 3'b010, 1, ob(2, 1, 2, 1, 4'b0000)));
    for (int i = 3; i <= 4; i++) tbl.push_back(mk(1, 3'b010, 0, ob(2, 1, i, 1, 4'b0000)));
    tbl.push_back(mk(1, 3'b001, 0, ob(1, 1, 1, 2, 4'b0000)));
    tbl.push_back(mk(1, 3'b010, 0, ob(0, 0, 0, 2, 4'b0100)));
    tbl.push_back(mk(1, 3'b100, 0, ob(0, 0, 0, 2, 4'b0100)));
    tbl.push_back(mk(1, 3'b001, 0, ob(1, 1, 1, 2, 4'b0100)));
    tbl.push_back(mk(1, 3'b011, 0, ob(0, 0, 0, 2, 4'b1100)));
    tbl.push_back(mk(1, 3'b000, 1, ob(0, 0, 0, 2, 4'b1000)));
    tbl.push_back(mk(1, 3'b100, 1, ob(0, 0, 0, 2, 4'b0000)));
    tbl.push_back(mk(0, 3'b001, 0, ob(0, 0, 0, 2, 4'b0000)));
    tbl.push_back(mk(0, 3'b011, 0, ob(0, 0, 0, 2, 4'b0000)));
    tbl.push_back(mk(1, 3'b001, 0, ob(1, 1, 1, 2, 4'b0000)));
    tbl.push_back(mk(0, 3'b100, 0, ob(1, 1, 1, 2, 4'b0000)));
    tbl.push_back(mk(0, 3'b111, 0, ob(1, 1, 1, 2, 4'b0000)));
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(ob(0, 0, 0, 0, 4'b0000));
    check("reset");
    rst = 1'b0;
    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));
    // S0 held from dwell 1: err_long appears when dwell reaches 65, dwell keeps counting
    for (int k = 2; k <= 66; k++)
      apply(mk(1, 3'b001, 0, ob(1, 1, k, 2, {3'b000, CHK && k >= 65})), $sformatf("long_dw%0d", k));
    #2 rst = 1'b1;
    #1;
    sb.push_back(ob(0, 0, 0, 0, 4'b0000));
    check("async_rst");
    #2 rst = 1'b0;
    apply(mk(1, 3'b000, 0, ob(0, 0, 0, 0, 4'b1000)), "unlocked_illegal");
    apply(mk(1, 3'b010, 0, ob(2, 1, 1, 0, 4'b1000)), "lock_on_s1");
    apply(mk(1, 3'b001, 0, ob(1, 1, 1, 1, {2'b10, CHK, 1'b0})), "short_into_s0");
    apply(mk(1, 3'b001, 1, ob(1, 1, 2, 1, 4'b0000)), "clr_all");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Receive-side checker for the one-hot lamp code driven by the traffic light controller. Samples the 3-bit lamp bus on each enabled cycle, decodes the active phase, and measures dwell time per phase. Flags illegal codes, out-of-order transitions and dwell violations, and counts completed light cycles. Sits on the controller's output bus as a passive observer feeding status/diagnostic logic.

## Interface
- `MIN_DWELL`, default 4: minimum legal samples per phase.
- `MAX_DWELL`, default 64: maximum legal samples per phase.
- `CNT_W`, default 8: width of the dwell and cycle counters; must hold `MAX_DWELL+1`.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  sample enable; the lamp bus is evaluated only when `en`=1.
- `lamp`  in  3  lamp code. Legal codes are S0=001, S1=010, S2=100.
- `clr`  in  1  synchronous clear of sticky error flags.
- `phase`  out  2  decoded phase: 0 none, 1 S0, 2 S1, 3 S2.
- `locked`  out  1  monitor is tracking a valid sequence.
- `dwell`  out  CNT_W  samples spent in the current phase, saturating.
- `cycle_cnt`  out  CNT_W  completed S0→S2→S1→S0 cycles, wrapping.
- `err_code`, `err_seq`, `err_short`, `err_long`  out  1 each  sticky error flags.

## Operation
- **Legal order:** 001→100→010→001. The expected successor is `{cur[0],cur[2:1]}`.
- **States:**
  - UNLOCKED: entered from reset.
  - TRACK: following a valid sequence.
  - FAULT: sequence broken, waiting to resync.
- **UNLOCKED:** on an enabled sample with a legal code, latch the phase, set `dwell`=1, go to TRACK. An illegal code sets `err_code` and the state stays UNLOCKED.
- **TRACK, enabled sample:**
  - Same code: increment `dwell`, saturating at all-ones. When `dwell` becomes `MAX_DWELL+1`, set `err_long`. The state stays TRACK.
  - Expected successor:
    - If the outgoing `dwell` < `MIN_DWELL`, set `err_short`.
    - Latch the new phase and set `dwell`=1.
    - Increment `cycle_cnt` when the new code is S0.
  - Legal but wrong successor: set `err_seq` and go to FAULT.
  - Illegal code (zero or multi-hot): set `err_code` and go to FAULT.
- **FAULT:**
  - Output values: `phase`=0, `dwell`=0, `locked`=0.
  - Resync only on S0: go to TRACK with `dwell`=1. `cycle_cnt` is not incremented.
  - Other legal codes are ignored. Illegal codes set `err_code`.
- **`locked`:** 1 only in TRACK.
- **`en`=0:** all state, counters and flags hold. `clr` is still honoured.
- **Error flags:** sticky. `clr`=1 zeroes them on the next edge. If a new error and `clr` occur in the same cycle, set wins.
- **`cycle_cnt`:** wraps modulo 2^CNT_W.

## Timing
- All outputs are registered. Sample at edge N is reflected after edge N; latency is 1 cycle.
- **Reset values:** state UNLOCKED, `phase`=0, `locked`=0, `dwell`=0, `cycle_cnt`=0, all error flags 0.
- **Reset mid-operation:** outputs clear immediately and asynchronously, regardless of `clk`/`en`.
- No handshake. The monitor never back-pressures the lamp bus.

## Configuration
- **`TLM_DWELL_CHECK_EN` defined:** MIN/MAX dwell checking is active; `err_short` and `err_long` are driven as above.
- **Not defined:** the comparators are omitted and `err_short`/`err_long` are tied to 0. Dwell counting, sequence checking and `cycle_cnt` are unchanged.

## Structure
- **Package `traffic_light_pkg`:**
  - Lamp code constants S0/S1/S2.
  - Monitor state enum (UNLOCKED/TRACK/FAULT).
  - 2-bit phase encoding.
  - Successor function.
- **Sub-module `traffic_light_dwell_counter`:**
  - Saturating CNT_W counter.
  - Controls: load-1, increment, zero.
  - Outputs: `short`/`long` compare against MIN/MAX.
- **Top-level:** FSM, decode, flags, `cycle_cnt`.

## Test plan
- **Reset then valid sequence:** reset, then `en`=1, lamp 001×4, 100×4, 010×4, 001×1. Expect `locked`=1, `cycle_cnt`=1, no errors, `phase` sequence 1,3,2,1.
- **Short dwell:** lamp 001×4, then 100×2, then 010. Expect `err_short`=1 and still `locked`=1. With the macro off, expect `err_short`=0.
- **Long dwell:** lamp 001 held 65 samples. Expect `err_long` set on sample 65; `dwell` continues to 66.
- **Wrong order then resync:** 001 then 010. Expect `err_seq`=1, `locked`=0, `phase`=0. Then 100 is ignored, then 001 re-locks with `dwell`=1 and `cycle_cnt` unchanged.
- **Illegal code, `clr` and `en` gating:** lamp 011 in TRACK gives `err_code`=1 and FAULT. Pulse `clr` together with lamp 000: `err_code` stays 1 (set wins). Then `clr` alone clears it. With `en`=0, lamp changes have no effect.
- **Async reset mid-phase:** assert `rst` between clock edges. All outputs go to reset values before the next `clk` edge.
